// File: rtl/stack_pkg.sv
// Shared constants and operation decode for the stack_lifo operand/return store.
// Optional feature macro used by stack_lifo: STACK_ERR_EN (sticky overflow/underflow flags).
package stack_pkg;

    localparam int STACK_WIDTH = 8;
    localparam int STACK_DEPTH = 3;

    typedef enum logic [1:0] {
        OP_NONE    = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } op_e;

    // Push+pop on an empty stack has nothing to replace, so it degrades to a plain push.
    function automatic op_e decode_op(
        input logic i_push,
        input logic i_pop,
        input logic i_full,
        input logic i_empty
    );
        op_e op;
        op = OP_NONE;
        if (i_push && i_pop && !i_empty) begin
            op = OP_REPLACE;
        end else if (i_push && !i_full) begin
            op = OP_PUSH;
        end else if (i_pop && !i_push && !i_empty) begin
            op = OP_POP;
        end
        return op;
    endfunction

endpackage

// File: rtl/stack_pointer.sv
// Up/down occupancy counter for stack_lifo; load port kept for reuse, tied off by the stack.
module stack_pointer #(
    parameter int PTR_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_load,
    input  logic [PTR_W-1:0] i_load_value,
    output logic [PTR_W-1:0] o_count
);

    logic [PTR_W-1:0] r_count;

    // Caller guarantees inc and dec are mutually exclusive and bounded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_inc) begin
            r_count <= r_count + PTR_W'(1);
        end else if (i_dec) begin
            r_count <= r_count - PTR_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/stack_lifo.sv
// LIFO stack with registered pop data and combinational full/empty decode of the pointer.
// Optional macro STACK_ERR_EN adds sticky overflow/underflow outputs.
module stack_lifo
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH,
    parameter int PTR_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    // push/pop are plain per-cycle strobes with no valid/ready handshake:
    // every cycle they are high performs one operation, bounded by full/empty.
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic [PTR_W-1:0] pointer
`ifdef STACK_ERR_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    op_e              w_op;
    logic [PTR_W-1:0] w_ptr;
    logic [PTR_W-1:0] w_top_idx;
    logic [PTR_W-1:0] w_wr_idx;
    logic             w_full;
    logic             w_empty;
    logic             w_inc;
    logic             w_dec;
    logic             w_wr_en;
    logic             w_rd_en;
    logic [WIDTH-1:0] w_top_data;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_data_out;

    assign w_full    = (w_ptr == PTR_W'(DEPTH));
    assign w_empty   = (w_ptr == '0);
    assign w_op      = decode_op(push, pop, w_full, w_empty);
    assign w_inc     = (w_op == OP_PUSH);
    assign w_dec     = (w_op == OP_POP);
    assign w_top_idx = w_ptr - PTR_W'(1);
    assign w_wr_en   = (w_op == OP_PUSH) || (w_op == OP_REPLACE);
    assign w_rd_en   = (w_op == OP_POP) || (w_op == OP_REPLACE);
    // A replace overwrites the current top; a push fills the next free slot.
    assign w_wr_idx  = (w_op == OP_REPLACE) ? w_top_idx : w_ptr;

    stack_pointer #(
        .PTR_W(PTR_W)
    ) u_ptr (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_inc       (w_inc),
        .i_dec       (w_dec),
        .i_load      (1'b0),
        .i_load_value('0),
        .o_count     (w_ptr)
    );

    always_comb begin
        w_top_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_top_idx == PTR_W'(i)) begin
                w_top_data = r_mem[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_en && (w_wr_idx == PTR_W'(i))) begin
                    r_mem[i] <= data_in;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_out <= '0;
        end else if (w_rd_en) begin
            r_data_out <= w_top_data;
        end
    end

    assign data_out = r_data_out;
    assign empty    = w_empty;
    assign full     = w_full;
    assign pointer  = w_ptr;

`ifdef STACK_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky until reset; a push+pop while full is a legal replace, not an overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (push && !pop && w_full) begin
                r_overflow <= 1'b1;
            end
            if (pop && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_stack_lifo.sv
// Self-checking bench for stack_lifo: directed scenarios then random strobes against a queue model.
module tb_stack_lifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int PTR_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;
    logic [PTR_W-1:0] pointer;
`ifdef STACK_ERR_EN
    logic             overflow;
    logic             underflow;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // reference model
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_dout;
    logic             exp_ovf;
    logic             exp_unf;

    stack_lifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .data_in  (data_in),
        .data_out (data_out),
        .empty    (empty),
        .full     (full),
        .pointer  (pointer)
`ifdef STACK_ERR_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
    endtask

    // Applies one clock edge of the specification's rules to the model.
    task automatic model_step(input logic p_push, input logic p_pop, input logic [WIDTH-1:0] din);
        int n;
        n = exp_q.size();
        if (p_push && !p_pop && n == DEPTH) exp_ovf = 1'b1;
        if (p_pop && n == 0) exp_unf = 1'b1;
        if (p_push && p_pop && n > 0) begin
            exp_dout = exp_q[n-1];
            exp_q[n-1] = din;
        end else if (p_push && n < DEPTH) begin
            exp_q.push_back(din);
        end else if (p_pop && !p_push && n > 0) begin
            exp_dout = exp_q.pop_back();
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".pointer"}, 32'(pointer), 32'(exp_q.size()));
        check({tag, ".empty"}, 32'(empty), 32'(exp_q.size() == 0));
        check({tag, ".full"}, 32'(full), 32'(exp_q.size() == DEPTH));
        check({tag, ".data_out"}, 32'(data_out), 32'(exp_dout));
`ifdef STACK_ERR_EN
        check({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(exp_unf));
`endif
    endtask

    // driver: called at a falling edge, drives for one rising edge, returns at the next falling edge
    task automatic drive(input logic p_push, input logic p_pop, input logic [WIDTH-1:0] din);
        push    = p_push;
        pop     = p_pop;
        data_in = din;
        @(posedge clk);
        model_step(p_push, p_pop, din);
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic do_push(input logic [WIDTH-1:0] din);
        drive(1'b1, 1'b0, din);
    endtask

    task automatic do_pop();
        drive(1'b0, 1'b1, $urandom_range(0, 255));
    endtask

    task automatic async_reset();
        #2 rst = 1'b0;
        model_reset();
        #1 check_state("async_rst");
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst     = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        model_reset();

        // reset
        repeat (2) @(negedge clk);
        check_state("reset");
        rst = 1'b1;
        @(negedge clk);
        check_state("post_reset");

        // fill
        do_push(8'hAA); check_state("fill1");
        do_push(8'hBB); check_state("fill2");
        do_push(8'hCC); check_state("fill3");
        check("fill.full_now", 32'(full), 32'd1);

        // drain
        do_pop(); check("drain1", 32'(data_out), 32'hCC); check_state("drain1");
        do_pop(); check("drain2", 32'(data_out), 32'hBB); check_state("drain2");
        do_pop(); check("drain3", 32'(data_out), 32'hAA); check_state("drain3");

        // overflow / underflow are ignored
        do_push(8'hAA); do_push(8'hBB); do_push(8'hCC);
        do_push(8'hDD); check_state("ovf_push");
        check("ovf.pointer_abs", 32'(pointer), 32'd3);
        do_pop(); check("ovf_pop", 32'(data_out), 32'hCC);
        do_pop(); do_pop(); check_state("drain_again");
        do_pop(); check("unf.hold", 32'(data_out), 32'hAA); check_state("unf_pop");

        // top replace
        do_push(8'h11); check_state("rep_push");
        drive(1'b1, 1'b1, 8'h22);
        check("rep.data_out", 32'(data_out), 32'h11);
        check("rep.pointer", 32'(pointer), 32'd1);
        check_state("rep");
        do_pop(); check("rep_pop", 32'(data_out), 32'h22); check_state("rep_pop");

        // push+pop on empty acts as push; replace when full
        drive(1'b1, 1'b1, 8'h33); check_state("pp_empty");
        do_push(8'h44); do_push(8'h55);
        drive(1'b1, 1'b1, 8'h66); check_state("rep_full");

        // async reset between edges with two entries held
        model_reset();
        rst = 1'b0; #1; rst = 1'b1;
        @(negedge clk);
        do_push(8'h01); do_push(8'h02);
        async_reset();
        check("async.pointer_abs", 32'(pointer), 32'd0);

        // random strobes
        for (int i = 0; i < 400; i++) begin
            logic rp;
            logic rq;
            rp = ($urandom_range(0, 99) < 50);
            rq = ($urandom_range(0, 99) < 45);
            drive(rp, rq, WIDTH'($urandom));
            check_state("rand");
            if (i == 200) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
